// File: rtl/display_page_sequencer.sv
// Button debounce / run control, page sequencing onto a three-digit 7-segment bank,
// and the snapshot/convert handshake with the binary-to-BCD converter.
module display_page_sequencer #(
  parameter int DATA_W          = 36,
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              btn_n,
  input  logic [DATA_W-1:0] count_in,
  output logic              run,
  output logic              conv_start,
  output logic [DATA_W-1:0] conv_data,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] bcd_in,
  output logic [1:0]        page,
  output logic [11:0]       seg_digits,
  output logic              busy
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {PAGE_BLANK, PAGE_HIGH, PAGE_MID, PAGE_LOW} page_t;
  typedef enum logic {CONV_IDLE, CONV_WAIT} conv_t;

  logic [1:0]        sync_reg, sync_next;
  logic              deb_level_reg, deb_level_next;
  logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
  logic              press_reg, press_next;
  logic              run_reg, run_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  page_t             page_reg, page_next;
  conv_t             conv_state_reg, conv_state_next;
  logic              conv_start_reg, conv_start_next;
  logic [DATA_W-1:0] conv_data_reg, conv_data_next;
  logic              busy_reg, busy_next;
  logic [DATA_W-1:0] snapshot_reg, snapshot_next;
  logic [DATA_W-1:0] pending_reg, pending_next;
  logic              pending_valid_reg, pending_valid_next;
  logic              tick;
  logic              btn_sync;

  assign btn_sync = sync_reg[1];
  assign tick     = (tick_cnt_reg == TICK_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg          <= 2'b11;
      deb_level_reg     <= 1'b1;
      deb_cnt_reg       <= '0;
      press_reg         <= 1'b0;
      run_reg           <= 1'b1;
      tick_cnt_reg      <= '0;
      page_reg          <= PAGE_BLANK;
      conv_state_reg    <= CONV_IDLE;
      conv_start_reg    <= 1'b0;
      conv_data_reg     <= '0;
      busy_reg          <= 1'b0;
      snapshot_reg      <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
    end else begin
      sync_reg          <= sync_next;
      deb_level_reg     <= deb_level_next;
      deb_cnt_reg       <= deb_cnt_next;
      press_reg         <= press_next;
      run_reg           <= run_next;
      tick_cnt_reg      <= tick_cnt_next;
      page_reg          <= page_next;
      conv_state_reg    <= conv_state_next;
      conv_start_reg    <= conv_start_next;
      conv_data_reg     <= conv_data_next;
      busy_reg          <= busy_next;
      snapshot_reg      <= snapshot_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
    end
  end

  always_comb begin
    sync_next          = {sync_reg[0], btn_n};
    deb_level_next     = deb_level_reg;
    deb_cnt_next       = deb_cnt_reg;
    press_next         = 1'b0;
    run_next           = run_reg ^ press_reg;
    tick_cnt_next      = tick ? '0 : tick_cnt_reg + TICK_W'(1);
    page_next          = page_reg;
    conv_state_next    = conv_state_reg;
    conv_start_next    = 1'b0;
    conv_data_next     = conv_data_reg;
    busy_next          = busy_reg;
    snapshot_next      = snapshot_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;

    // Any sample matching the accepted level restarts the stability count.
    if (btn_sync == deb_level_reg) begin
      deb_cnt_next = '0;
    end else if (deb_cnt_reg == DEB_LAST) begin
      deb_level_next = btn_sync;
      deb_cnt_next   = '0;
      press_next     = ~btn_sync;
    end else begin
      deb_cnt_next = deb_cnt_reg + DEB_W'(1);
    end

    if (tick) begin
      case (page_reg)
        PAGE_BLANK: page_next = PAGE_HIGH;
        PAGE_HIGH:  page_next = PAGE_MID;
        PAGE_MID:   page_next = PAGE_LOW;
        default:    page_next = PAGE_BLANK;
      endcase
    end

    // Commit sees the pre-edge pending_valid; a same-cycle completion re-arms it below.
    if (tick && page_reg == PAGE_BLANK && pending_valid_reg) begin
      snapshot_next      = pending_reg;
      pending_valid_next = 1'b0;
    end

    case (conv_state_reg)
      CONV_IDLE: begin
        if (tick && page_reg == PAGE_LOW && run_reg) begin
          conv_data_next  = count_in;
          conv_start_next = 1'b1;
          busy_next       = 1'b1;
          conv_state_next = CONV_WAIT;
        end
      end
      default: begin
        if (conv_done && !conv_start_reg) begin
          pending_next       = bcd_in;
          pending_valid_next = 1'b1;
          busy_next          = 1'b0;
          conv_state_next    = CONV_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    case (page_reg)
      PAGE_HIGH: seg_digits = snapshot_reg[35:24];
      PAGE_MID:  seg_digits = snapshot_reg[23:12];
      PAGE_LOW:  seg_digits = snapshot_reg[11:0];
      default:   seg_digits = 12'hFFF;
    endcase
  end

  assign run        = run_reg;
  assign conv_start = conv_start_reg;
  assign conv_data  = conv_data_reg;
  assign page       = page_reg;
  assign busy       = busy_reg;

endmodule

// File: doc/display_page_sequencer.md
Name: display_page_sequencer

Overview:
Controller sitting between the free-running event counter, the binary-to-BCD converter and the three-digit 7-segment bank. It debounces the start/stop button and drives the counter run enable. It also sequences snapshot/convert requests to the BCD converter over a start/done handshake. The 9 BCD digits are paged onto HEX2..HEX0 as BLANK, HIGH, MID, LOW on a tick enable derived from CLOCK_50, with no derived clocks.

Parameters:
DATA_W, 36, width of counter value and of the BCD digit bus (9 digits x 4 bits).
TICK_DIV, 25000000, CLOCK_50 cycles per display page; minimum 2.
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level change; minimum 1.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
reset_n  in  1  asynchronous active-low reset.
btn_n  in  1  raw push button, active-low, asynchronous to CLOCK_50.
count_in  in  DATA_W  live counter value.
run  out  1  counter enable; high = counting.
conv_start  out  1  one-cycle pulse requesting a conversion of conv_data.
conv_data  out  DATA_W  counter snapshot held stable from conv_start until conv_done.
conv_done  in  1  converter completion, one-cycle pulse; bcd_in is valid in that cycle.
bcd_in  in  DATA_W  converter result, digit 8 in [35:32] down to digit 0 in [3:0].
page  out  2  current page: 0 BLANK, 1 HIGH, 2 MID, 3 LOW.
seg_digits  out  12  three BCD codes for HEX2,HEX1,HEX0; 4'hF = blank.
busy  out  1  high while a conversion is outstanding.

Behaviour:
- Reset (async, reset_n low): run=1, page=BLANK, conv_start=0, conv_data=0, busy=0, snapshot=0, pending=0, pending_valid=0, tick counter=0, debounced level=released, sync flops=1.
- Button path: 2-flop synchronizer, then debounce counter. Accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current debounced level. Any bounce resets the count.
- Press event: one-cycle pulse on the accepted released->pressed transition. Release generates no event. Each press toggles run on the following edge. Holding the button produces exactly one toggle.
- Tick: counter 0..TICK_DIV-1, free-running regardless of run. tick=1 in the cycle count==TICK_DIV-1, and the counter wraps to 0.
- Page FSM, advances on tick only: BLANK->HIGH->MID->LOW->BLANK.
- seg_digits is combinational from page and snapshot:
  - BLANK = 12'hFFF
  - HIGH = snapshot[35:24]
  - MID = snapshot[23:12]
  - LOW = snapshot[11:0]
- Conversion FSM, states IDLE, WAIT:
  - Request: on the tick edge where page goes LOW->BLANK, and only if run=1 and state=IDLE.
  - On that edge: conv_data<=count_in, conv_start<=1, busy<=1, state<=WAIT.
  - conv_start deasserts on the next edge, so the pulse is exactly one cycle.
  - In WAIT, on conv_done=1: pending<=bcd_in, pending_valid<=1, busy<=0, state<=IDLE. conv_done is accepted no earlier than the cycle after conv_start.
  - conv_done while IDLE is ignored.
  - A request while in WAIT is dropped. There is no queueing and conv_data is not changed.
- Commit: on the tick edge where page goes BLANK->HIGH, if pending_valid=1 then snapshot<=pending and pending_valid<=0. Otherwise the snapshot is kept.
  - The snapshot never changes during HIGH, MID or LOW, so a displayed number is never torn.
  - If conv_done and the commit tick occur in the same cycle, the commit uses the old pending_valid. The new result commits one full page cycle later.
- run=0: no new requests; the display freezes on the last committed value and pages keep cycling. An in-flight conversion still completes and commits normally.
- Press event and tick in the same cycle are processed independently.
- Reset mid-conversion aborts the transaction; a later stray conv_done is ignored because the FSM is in IDLE.

Test Plan:
- Sim params TICK_DIV=4, DEBOUNCE_CYCLES=3. Release reset with btn_n=1 -> run=1, page=0, seg_digits=12'hFFF; page steps 0,1,2,3,0 every 4 cycles; HIGH/MID/LOW show 12'h000.
- count_in=36'h000000ABC at LOW->BLANK edge; converter returns bcd_in=36'h000002748 two cycles after conv_start -> conv_start high exactly 1 cycle, conv_data=36'hABC; busy high until conv_done. Next cycle shows HIGH=12'h000, MID=12'h002, LOW=12'h748.
- btn_n low for 2 cycles, high 1, then low for 10 cycles -> exactly one toggle, with run=0 occurring 3 accepted samples after the stable low. A later LOW->BLANK edge produces no conv_start, and seg_digits keeps its prior values.
- Withhold conv_done for 20 cycles -> the second LOW->BLANK edge produces no conv_start and busy stays 1. When conv_done arrives, its value commits at the next BLANK->HIGH edge only.
- Assert conv_done on the same cycle as the BLANK->HIGH tick -> snapshot is unchanged for that cycle; the new value is displayed from the following HIGH page.
- Pulse reset_n low while busy=1, then inject conv_done -> all outputs return to reset values, and conv_done has no effect (pending_valid stays 0).
